// File: rtl/cpu_out_mon_pkg.sv
// Shared types, default constants and width helper for the CPU OUT-bus monitor.
package cpu_out_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W        = 32;
  localparam int unsigned DEF_DEPTH         = 8;
  localparam int unsigned DEF_CYC_W         = 16;
  localparam int unsigned DEF_STABLE_CYCLES = 64;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_out_mon_fifo.sv
// First-word-fall-through FIFO holding captured OUT-bus entries.
module cpu_out_mon_fifo
  import cpu_out_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_W + DEF_CYC_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     push_data,
  output logic [WIDTH-1:0]     head_data,
  output logic                 full,
  output logic                 empty,
  output logic [log2(DEPTH):0] count
);
  localparam int unsigned AW = log2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO still lands when the head leaves on the same edge.
  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW + 1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_out_monitor.sv
// Logs value changes of the CPU OUT bus into a FIFO and flags completion on a stable bus.
// Per-entry cycle stamps are built only when CPU_OUT_MON_TIMESTAMP_EN is defined.
module cpu_out_monitor
  import cpu_out_mon_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned CYC_W         = DEF_CYC_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [DATA_W-1:0]    OUT_IN,
  input  logic                 RD_READY,
  output logic                 RD_VALID,
  output logic [DATA_W-1:0]    RD_DATA,
  output logic [CYC_W-1:0]     RD_CYCLE,
  output logic [log2(DEPTH):0] COUNT,
  output logic                 OVERFLOW,
  output logic                 DONE
);
  localparam int unsigned SW = log2(STABLE_CYCLES + 1);
`ifdef CPU_OUT_MON_TIMESTAMP_EN
  localparam int unsigned ST_W = CYC_W;
`else
  localparam int unsigned ST_W = 0;
`endif
  localparam int unsigned FW = DATA_W + ST_W;

  state_t            state;
  logic [DATA_W-1:0] prev;
  logic [SW-1:0]     stable;
  logic [SW-1:0]     stable_inc;
  logic              changed;
  logic              push;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              done;
  logic [FW-1:0]     push_data;
  logic [FW-1:0]     head;

  always_comb begin
    changed    = (OUT_IN != prev);
    stable_inc = stable + 1'b1;
    push       = 1'b0;
    case (state)
      ST_IDLE: push = EN;
      ST_RUN:  push = EN && changed;
      default: push = 1'b0;
    endcase
  end

`ifdef CPU_OUT_MON_TIMESTAMP_EN
  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] cyc_next;

  assign cyc_next = (cyc == '1) ? cyc : cyc + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cyc <= '0;
    else if (state == ST_IDLE && EN) cyc <= '0;
    else if (state == ST_RUN) cyc <= cyc_next;
  end

  assign push_data = {OUT_IN, (state == ST_RUN) ? cyc_next : {CYC_W{1'b0}}};
  assign RD_CYCLE  = head[CYC_W-1:0];
`else
  assign push_data = OUT_IN;
  assign RD_CYCLE  = '0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      prev     <= '0;
      stable   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Full implies non-empty, so RD_READY alone decides whether the head frees a slot.
      if (push && full && !RD_READY) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (EN) begin
            prev   <= OUT_IN;
            stable <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!EN) begin
            state <= ST_IDLE;
          end else if (changed) begin
            prev   <= OUT_IN;
            stable <= '0;
          end else begin
            stable <= stable_inc;
            if (stable_inc == SW'(STABLE_CYCLES)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!EN) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cpu_out_mon_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (push),
    .pop       (RD_READY),
    .push_data (push_data),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (COUNT)
  );

  assign RD_VALID = !empty;
  assign RD_DATA  = head[FW-1 -: DATA_W];
  assign OVERFLOW = overflow;
  assign DONE     = done;

endmodule

// File: tb/tb_cpu_out_monitor.sv
// Randomized and directed bench for cpu_out_monitor against a queue-based reference model.
module tb_cpu_out_monitor;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned STB = 4;
  localparam int unsigned CYC_MAX = (1 << CW) - 1;
`ifdef CPU_OUT_MON_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          EN = 1'b0;
  logic [DW-1:0] OUT_IN = '0;
  logic          RD_READY = 1'b0;
  logic          RD_VALID;
  logic [DW-1:0] RD_DATA;
  logic [CW-1:0] RD_CYCLE;
  logic [3:0]    COUNT;
  logic          OVERFLOW;
  logic          DONE;

  int unsigned total = 0;
  int unsigned bad   = 0;

  cpu_out_monitor #(
    .DATA_W        (DW),
    .DEPTH         (DEP),
    .CYC_W         (CW),
    .STABLE_CYCLES (STB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .OUT_IN   (OUT_IN),
    .RD_READY (RD_READY),
    .RD_VALID (RD_VALID),
    .RD_DATA  (RD_DATA),
    .RD_CYCLE (RD_CYCLE),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   s;
  } ent_t;

  ent_t          q[$];
  bit            armed, finished, m_ovf;
  logic [DW-1:0] m_prev;
  int unsigned   m_runs, m_same;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_stamp(input int unsigned s);
    return TS ? 64'(s) : 64'd0;
  endfunction

  function automatic void model_reset();
    q.delete();
    armed = 0; finished = 0; m_ovf = 0;
    m_prev = '0; m_runs = 0; m_same = 0;
  endfunction

  function automatic void model_edge(input bit en, input logic [DW-1:0] v, input bit rdy);
    bit          pop, push;
    int unsigned stamp;
    pop = rdy && (q.size() > 0);
    push = 0; stamp = 0;
    if (finished) begin
      if (!en) begin finished = 0; armed = 0; end
    end else if (!armed) begin
      if (en) begin
        push = 1; stamp = 0; m_prev = v; m_runs = 0; m_same = 0; armed = 1;
      end
    end else begin
      if (m_runs < CYC_MAX) m_runs++;
      if (!en) armed = 0;
      else if (v != m_prev) begin
        push = 1; stamp = m_runs; m_prev = v; m_same = 0;
      end else begin
        m_same++;
        if (m_same == STB) finished = 1;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEP) q.push_back('{d: v, s: stamp});
      else m_ovf = 1;
    end
  endfunction

  task automatic check_outputs();
    chk("valid", RD_VALID, q.size() != 0);
    chk("count", COUNT, q.size());
    chk("overflow", OVERFLOW, m_ovf);
    chk("done", DONE, finished);
    if (q.size() != 0) begin
      chk("data", RD_DATA, q[0].d);
      chk("cycle", RD_CYCLE, exp_stamp(q[0].s));
    end
  endtask

  task automatic step(input bit en, input logic [DW-1:0] v, input bit rdy);
    EN = en; OUT_IN = v; RD_READY = rdy;
    @(posedge CLK);
    model_edge(en, v, rdy);
    #1 check_outputs();
  endtask

  task automatic async_reset();
    #3 RST = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", RD_VALID, 0);
    chk("rst_data", RD_DATA, 0);
    chk("rst_cycle", RD_CYCLE, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_done", DONE, 0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    model_reset();
    async_reset();

    // basic capture: 0x0, then 0x5 on the 4th RUN edge, 0xA on the 8th
    step(1, 32'h0, 0);
    repeat (3) step(1, 32'h0, 0);
    step(1, 32'h5, 0);
    repeat (3) step(1, 32'h5, 0);
    step(1, 32'hA, 0);
    chk("cap_count", COUNT, 3);
    chk("cap_head0", RD_DATA, 32'h0);
    chk("cap_stamp0", RD_CYCLE, 0);
    step(1, 32'hA, 1);
    chk("cap_head1", RD_DATA, 32'h5);
    chk("cap_stamp1", RD_CYCLE, exp_stamp(4));
    step(1, 32'hA, 1);
    chk("cap_head2", RD_DATA, 32'hA);
    chk("cap_stamp2", RD_CYCLE, exp_stamp(8));
    step(1, 32'hA, 1);
    step(0, 32'hA, 0);

    // reset while three entries are held
    step(1, 32'h1, 0);
    step(1, 32'h2, 0);
    step(1, 32'h3, 0);
    chk("pre_rst_count", COUNT, 3);
    chk("pre_rst_done", DONE, 0);
    async_reset();
    step(1, 32'h7, 0);
    chk("post_rst_stamp", RD_CYCLE, 0);
    chk("post_rst_data", RD_DATA, 32'h7);

    // completion on the 4th unchanged RUN edge
    step(0, 32'h7, 0);
    step(1, 32'h2A, 0);
    repeat (3) step(1, 32'h2A, 0);
    chk("done_early", DONE, 0);
    step(1, 32'h2A, 0);
    chk("done_set", DONE, 1);
    step(1, 32'h99, 0);
    step(1, 32'h55, 0);
    chk("done_nopush", COUNT, 2);
    step(0, 32'h55, 1);
    chk("done_clear", DONE, 0);
    repeat (3) step(0, 32'h55, 1);

    // full boundary: simultaneous push and pop, then overflow
    async_reset();
    step(1, 32'd100, 0);
    for (int unsigned i = 1; i < 8; i++) step(1, 32'd100 + i, 0);
    chk("full_count", COUNT, 8);
    step(1, 32'd200, 1);
    chk("fullpp_count", COUNT, 8);
    chk("fullpp_ovf", OVERFLOW, 0);
    chk("fullpp_head", RD_DATA, 32'd101);
    for (int unsigned i = 0; i < 10; i++) step(1, 32'd300 + i, 0);
    chk("ovf_count", COUNT, 8);
    chk("ovf_flag", OVERFLOW, 1);
    chk("ovf_head", RD_DATA, 32'd101);
    repeat (9) step(0, 32'd0, 1);

    // disarm: changes while idle push nothing; re-arm stamps 0
    step(1, 32'h11, 0);
    step(1, 32'h11, 0);
    step(0, 32'h22, 0);
    step(0, 32'h33, 0);
    chk("disarm_count", COUNT, 1);
    step(1, 32'h44, 1);
    chk("rearm_data", RD_DATA, 32'h44);
    chk("rearm_stamp", RD_CYCLE, 0);
    step(1, 32'h44, 1);

    // randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      step($urandom_range(0, 15) != 0, 32'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
